// File: rtl/req_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The arbiter takes the slave modport; request sources take the master modport.
interface req_rr_arbiter_if #(
  parameter int unsigned N = 2
);
  localparam int unsigned IDW = (N > 2) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, per-ownership hold limit
// and a programmable idle gap after every release.
module req_rr_arbiter #(
  parameter int unsigned N          = 2,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  req_rr_arbiter_if.slave bus
);

  localparam int unsigned IDW       = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned HOLD_LAST = MAX_HOLD - 1;
  localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           to_q, to_d;

  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic           release_w;

  // Circular priority scan starting at ptr: first requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDW'((32'(ptr_q) + k) % N);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic for IDLE/GRANT/GAP.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    to_d      = 1'b0;
    release_w = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = N'(1) << win_idx;
          id_d    = win_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // A release on the owner's own drop takes precedence over the hold
        // limit, so timeout only fires when the owner is still requesting.
        if (!bus.req[id_q]) begin
          release_w = 1'b1;
        end else if (hold_q == HW'(HOLD_LAST)) begin
          release_w = 1'b1;
          to_d      = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end

        if (release_w) begin
          gnt_d = '0;
          id_d  = '0;
          ptr_d = IDW'((32'(id_q) + 1) % N);
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  // State and output registers; async clear drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Directed and random bench for req_rr_arbiter (N=2, MAX_HOLD=4, GAP_CYCLES=1).
module tb_req_rr_arbiter;

  logic clk;
  logic rst_n;

  req_rr_arbiter_if #(.N(2)) bus ();

  req_rr_arbiter #(
    .N          (2),
    .MAX_HOLD   (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] g;
    logic       t;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: reset low across one edge, released away from the edge.
  task automatic do_reset(input logic [1:0] r);
    bus.req = r;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive req for the next edge, queue the expected outputs, compare after the edge.
  task automatic cyc(input logic [1:0] r, input logic [1:0] eg, input logic et, input string tag);
    exp_t e;
    bus.req = r;
    e.g = eg;
    e.t = et;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    step++;
    if (sbq.size() == 0) begin
      chk($sformatf("%s_%0d_sbq_empty", tag, step), 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s_%0d_gnt", tag, step), 32'(bus.gnt), 32'(e.g));
      chk($sformatf("%s_%0d_id", tag, step), 32'(bus.gnt_id), (e.g == 2'b10) ? 32'd1 : 32'd0);
      chk($sformatf("%s_%0d_busy", tag, step), 32'(bus.busy), 32'(|e.g));
      chk($sformatf("%s_%0d_to", tag, step), 32'(bus.timeout), 32'(e.t));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = 2'b00;
    rst_n   = 1'b0;
    #2;
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_id", 32'(bus.gnt_id), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_to", 32'(bus.timeout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lone requester: 4-cycle grant, forced release, 2 idle cycles, re-grant.
    for (int i = 0; i < 4; i++) cyc(2'b01, 2'b01, 1'b0, "t1_hold");
    cyc(2'b01, 2'b00, 1'b1, "t1_to");
    cyc(2'b01, 2'b00, 1'b0, "t1_gap");
    cyc(2'b01, 2'b01, 1'b0, "t1_regrant");

    // Both requesting: strict rotation with timeout after each grant.
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b01, 1'b0, "t2_g0");
    cyc(2'b11, 2'b00, 1'b1, "t2_to0");
    cyc(2'b11, 2'b00, 1'b0, "t2_gap0");
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b10, 1'b0, "t2_g1");
    cyc(2'b11, 2'b00, 1'b1, "t2_to1");
    cyc(2'b11, 2'b00, 1'b0, "t2_gap1");
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b01, 1'b0, "t2_g0b");

    // req1 for 2 cycles, req2 rising one cycle later.
    do_reset(2'b00);
    cyc(2'b01, 2'b01, 1'b0, "t3_g0");
    cyc(2'b11, 2'b01, 1'b0, "t3_g0");
    cyc(2'b10, 2'b00, 1'b0, "t3_rel");
    cyc(2'b10, 2'b00, 1'b0, "t3_gap");
    cyc(2'b10, 2'b10, 1'b0, "t3_g1");
    cyc(2'b00, 2'b00, 1'b0, "t3_rel1");

    // Owner drops on the hold-limit edge: normal release, ptr still advances.
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b01, 1'b0, "t4_g0");
    cyc(2'b10, 2'b00, 1'b0, "t4_rel");
    cyc(2'b11, 2'b00, 1'b0, "t4_gap");
    cyc(2'b11, 2'b10, 1'b0, "t4_ptr");

    // Async reset while requester 1 owns (ptr=1); ptr must return to 0.
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b01, 1'b0, "t5_g0");
    cyc(2'b11, 2'b00, 1'b1, "t5_to");
    cyc(2'b11, 2'b00, 1'b0, "t5_gap");
    cyc(2'b11, 2'b10, 1'b0, "t5_g1");
    cyc(2'b11, 2'b10, 1'b0, "t5_g1");
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_async_busy", 32'(bus.busy), 32'd0);
    chk("t5_async_to", 32'(bus.timeout), 32'd0);
    chk("t5_async_id", 32'(bus.gnt_id), 32'd0);
    @(posedge clk);
    #1;
    chk("t5_inreset_gnt", 32'(bus.gnt), 32'd0);
    rst_n = 1'b1;
    cyc(2'b11, 2'b01, 1'b0, "t5_first");

    // Random requests on a 12-unit grid, invariants checked every cycle.
    do_reset(2'b00);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          bus.req = 2'($urandom_range(0, 3));
          #12;
        end
        bus.req = 2'b00;
      end
      begin
        logic [1:0] rs;
        logic [1:0] prev_gnt;
        logic       prev_to;
        int         run;
        int         low;
        bit         had;
        prev_gnt = 2'b00;
        prev_to  = 1'b0;
        run      = 0;
        low      = 0;
        had      = 1'b0;
        for (int c = 0; c < 16; c++) begin
          @(posedge clk);
          rs = bus.req;
          @(negedge clk);
          chk($sformatf("rnd_%0d_onehot", c), 32'($countones(bus.gnt) <= 1), 32'd1);
          chk($sformatf("rnd_%0d_busy", c), 32'(bus.busy), 32'(|bus.gnt));
          chk($sformatf("rnd_%0d_id", c), 32'(bus.gnt_id), (bus.gnt == 2'b10) ? 32'd1 : 32'd0);
          chk($sformatf("rnd_%0d_to_pulse", c), 32'(bus.timeout & prev_to), 32'd0);
          if (bus.gnt != 2'b00) begin
            if (bus.gnt == prev_gnt) begin
              run++;
            end else begin
              run = 1;
              chk($sformatf("rnd_%0d_sampled", c), 32'(|(bus.gnt & rs)), 32'd1);
              if (had) chk($sformatf("rnd_%0d_gap", c), 32'(low >= 2), 32'd1);
            end
            low = 0;
            had = 1'b1;
          end else begin
            run = 0;
            low++;
          end
          chk($sformatf("rnd_%0d_hold", c), 32'(run <= 4), 32'd1);
          prev_gnt = bus.gnt;
          prev_to  = bus.timeout;
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
